// File: rtl/net_ingr_prot_handler_if.sv
// AXI-stream bundle for the ingress protocol handler.
// master drives payload/valid, slave drives ready.
interface net_ingr_prot_handler_if #(
  parameter int DW    = 64,
  parameter int DESTW = 4
);
  localparam int DESTW_P = (DESTW < 1) ? 1 : DESTW;

  logic [DW-1:0]      tdata;
  logic [DESTW_P-1:0] tdest;
  logic [DW/8-1:0]    tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (
    output tdata, tdest, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tdest, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/net_ingr_prot_handler.sv
// Ingress protocol enforcer: one-beat slice, stall timeout,
// packet drop and null-terminator insertion toward the app.
module net_ingr_prot_handler #(
  parameter int AXIS_BUS_WIDTH      = 64,
  parameter int AXIS_DEST_WIDTH     = 4,
  parameter int INGR_TIMEOUT_CYCLES = 15,
  parameter int DROP_COUNT_WIDTH    = 16
) (
  input  logic aclk,
  input  logic aresetn,
  net_ingr_prot_handler_if.slave  axis_ingr_in,
  net_ingr_prot_handler_if.master axis_ingr_out,
  output logic timeout_error_irq,
  input  logic timeout_error_clear,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int DEST_W = (AXIS_DEST_WIDTH < 1) ? 1 : AXIS_DEST_WIDTH;
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
  localparam int CNT_W  = $clog2(INGR_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(INGR_TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    PASS = 2'd0,
    DROP = 2'd1,
    TERM = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AXIS_BUS_WIDTH-1:0] data_q, data_d;
  logic [DEST_W-1:0]         dest_q, dest_d;
  logic [KEEP_W-1:0]         keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      vld_q, vld_d;
  logic                      part_q, part_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sticky_q, sticky_d;
  logic [DROP_COUNT_WIDTH-1:0] drops_q, drops_d;

  logic in_rdy;
  logic in_acc;
  logic out_vld;
  logic out_last;
  logic out_rdy;
  logic tmo;
  logic is_term;

  assign is_term = (state_q == TERM);
  assign out_rdy = axis_ingr_out.tready;
  assign tmo     = (cnt_q == TMO);

  // Terminator beat overrides the slice contents while in TERM.
  assign out_vld  = aresetn && (is_term || vld_q);
  assign out_last = is_term ? 1'b1 : last_q;

  assign axis_ingr_out.tvalid = out_vld;
  assign axis_ingr_out.tlast  = out_last;
  assign axis_ingr_out.tdata  = is_term ? '0 : data_q;
  assign axis_ingr_out.tdest  = is_term ? '0 : dest_q;
  assign axis_ingr_out.tkeep  = is_term ? '0 : keep_q;

  always_comb begin
    in_rdy = 1'b0;
    unique case (state_q)
      PASS:    in_rdy = (out_rdy || !vld_q) && !tmo;
      DROP:    in_rdy = 1'b1;
      default: in_rdy = 1'b0;
    endcase
    in_rdy = in_rdy && aresetn;
  end

  assign axis_ingr_in.tready = in_rdy;
  assign in_acc = axis_ingr_in.tvalid && in_rdy;

  assign timeout_error_irq = tmo || sticky_q;
  assign drop_count        = drops_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dest_d   = dest_q;
    keep_d   = keep_q;
    last_d   = last_q;
    vld_d    = vld_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    drops_d  = drops_q;

    if (out_vld && out_rdy) part_d = !out_last;

    if (timeout_error_clear || tmo || !(out_vld && !out_rdy)) begin
      cnt_d = '0;
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (tmo) sticky_d = 1'b1;
    else if (timeout_error_clear) sticky_d = 1'b0;

    if (tmo && (drops_q != '1)) drops_d = drops_q + DROP_COUNT_WIDTH'(1);

    unique case (state_q)
      PASS: begin
        if (in_acc) begin
          data_d = axis_ingr_in.tdata;
          dest_d = axis_ingr_in.tdest;
          keep_d = axis_ingr_in.tkeep;
          last_d = axis_ingr_in.tlast;
          vld_d  = 1'b1;
        end else if (out_rdy) begin
          vld_d = 1'b0;
        end
        // A stalled tail beat only needs closing if the app saw a head.
        if (tmo) begin
          vld_d = 1'b0;
          if (last_q) state_d = part_d ? TERM : PASS;
          else        state_d = DROP;
        end
      end
      DROP: begin
        vld_d = 1'b0;
        if (in_acc && axis_ingr_in.tlast) begin
          state_d = part_q ? TERM : PASS;
        end
      end
      TERM: begin
        if (out_rdy) begin
          part_d  = 1'b0;
          state_d = PASS;
        end else if (tmo) begin
          state_d = DROP;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= PASS;
      data_q   <= '0;
      dest_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      vld_q    <= 1'b0;
      part_q   <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      drops_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      vld_q    <= vld_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      drops_q  <= drops_d;
    end
  end

endmodule

// File: tb/tb_net_ingr_prot_handler.sv
// Bench for net_ingr_prot_handler: random packets against a
// packet-level expectation of what the application must see.
module tb_net_ingr_prot_handler;

  localparam int TMO = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  dst;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        timeout_error_clear = 1'b0;
  logic        timeout_error_irq;
  logic [15:0] drop_count;

  net_ingr_prot_handler_if #(.DW(64), .DESTW(4)) in_if ();
  net_ingr_prot_handler_if #(.DW(64), .DESTW(4)) out_if ();

  net_ingr_prot_handler #(
    .AXIS_BUS_WIDTH(64),
    .AXIS_DEST_WIDTH(4),
    .INGR_TIMEOUT_CYCLES(TMO),
    .DROP_COUNT_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .axis_ingr_in(in_if),
    .axis_ingr_out(out_if),
    .timeout_error_irq(timeout_error_irq),
    .timeout_error_clear(timeout_error_clear),
    .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  beat_t src[$];
  beat_t got[$];
  beat_t exp_q[$];
  beat_t pkt[$];
  beat_t term_b;
  int in_cyc[$];
  int out_cyc[$];
  int rdy_mode = 0;
  int rdy_lim = 0;
  int low_run = 0;
  int exp_drops = 0;
  int stalls;
  bit in_acc, stall_s, irq_s, ov_s, ir_s;
  logic [15:0] drop_s;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic gen(int n);
    beat_t b;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      b.d   = {$urandom, $urandom};
      b.dst = 4'($urandom);
      b.k   = 8'($urandom_range(1, 255));
      b.l   = (i == n - 1);
      pkt.push_back(b);
    end
  endtask

  task automatic drive();
    bit r;
    if (src.size() > 0) begin
      in_if.tvalid = 1'b1;
      {in_if.tdata, in_if.tdest, in_if.tkeep, in_if.tlast} = src[0];
    end else begin
      in_if.tvalid = 1'b0;
      {in_if.tdata, in_if.tdest, in_if.tkeep, in_if.tlast} = '0;
    end
    case (rdy_mode)
      0: r = 1'b1;
      1: begin
        r = ($urandom_range(0, 1) == 1) || (low_run >= 2);
        low_run = r ? 0 : low_run + 1;
      end
      2: r = 1'b0;
      default: r = (got.size() < rdy_lim);
    endcase
    out_if.tready = r;
  endtask

  task automatic tick();
    @(negedge aclk);
    in_acc  = in_if.tvalid && in_if.tready;
    stall_s = out_if.tvalid && !out_if.tready;
    irq_s   = timeout_error_irq;
    ov_s    = out_if.tvalid;
    ir_s    = in_if.tready;
    drop_s  = drop_count;
    if (aresetn && out_if.tvalid && out_if.tready) begin
      got.push_back({out_if.tdata, out_if.tdest,
                     out_if.tkeep, out_if.tlast});
      out_cyc.push_back(cyc);
    end
    if (in_acc) in_cyc.push_back(cyc);
    @(posedge aclk);
    #1;
    cyc++;
    if (in_acc) void'(src.pop_front());
    drive();
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while ((src.size() != 0 || out_if.tvalid) && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("%s_done", tag), n < 300, 1);
    tick();
    tick();
  endtask

  task automatic wait_irq(string tag, output int st);
    int n = 0;
    st = 0;
    while (n < 100) begin
      tick();
      n++;
      if (irq_s) break;
      if (stall_s) st++;
    end
    chk($sformatf("%s_irq", tag), irq_s, 1);
  endtask

  task automatic wait_drops(string tag, int target);
    int n = 0;
    while (int'(drop_s) != target && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("%s_drops", tag), drop_s, target);
  endtask

  task automatic cmp_q(string tag);
    chk($sformatf("%s_n", tag), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  task automatic clear_irq(string tag);
    timeout_error_clear = 1'b1;
    tick();
    chk($sformatf("%s_hold", tag), irq_s, 1);
    timeout_error_clear = 1'b0;
    tick();
    chk($sformatf("%s_clr", tag), irq_s, 0);
  endtask

  task automatic start(int mode);
    got.delete();
    exp_q.delete();
    in_cyc.delete();
    out_cyc.delete();
    rdy_mode = mode;
  endtask

  task automatic push_src_exp(bit to_exp);
    foreach (pkt[i]) begin
      src.push_back(pkt[i]);
      if (to_exp) exp_q.push_back(pkt[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    beat_t a0;
    term_b = '{d: 64'd0, dst: 4'd0, k: 8'd0, l: 1'b1};
    drive();

    // reset
    tick();
    tick();
    chk("rst_out_vld", ov_s, 0);
    chk("rst_in_rdy", ir_s, 0);
    aresetn = 1'b1;
    tick();
    chk("rst_irq", irq_s, 0);
    chk("rst_drops", drop_s, 0);
    chk("rst_out_vld2", ov_s, 0);
    chk("idle_in_rdy", ir_s, 1);

    // pass-through, full rate
    start(0);
    repeat (3) begin
      gen(4);
      push_src_exp(1);
    end
    drive();
    wait_idle("s1");
    cmp_q("s1");
    chk("s1_lat_n", out_cyc.size(), in_cyc.size());
    for (int i = 0; i < in_cyc.size(); i++) begin
      if (i < out_cyc.size()) chk("s1_lat", out_cyc[i] - in_cyc[i], 1);
    end
    if (in_cyc.size() == 12) chk("s1_rate", in_cyc[11] - in_cyc[0], 11);
    chk("s1_drops", drop_s, 0);
    chk("s1_irq", irq_s, 0);

    // pass-through, random short back-pressure
    start(1);
    repeat (4) begin
      gen($urandom_range(1, 6));
      push_src_exp(1);
    end
    drive();
    wait_idle("s1b");
    cmp_q("s1b");
    chk("s1b_drops", drop_s, 0);

    // mid-packet stall
    start(3);
    k = $urandom_range(1, 3);
    rdy_lim = k;
    gen(5);
    push_src_exp(0);
    for (int i = 0; i < k; i++) exp_q.push_back(pkt[i]);
    exp_q.push_back(term_b);
    drive();
    wait_irq("s2", stalls);
    chk("s2_stalls", stalls, TMO);
    chk("s2_drop_rdy", in_if.tready, 1);
    chk("s2_drop_vld", out_if.tvalid, 0);
    exp_drops++;
    rdy_mode = 0;
    drive();
    wait_idle("s2");
    cmp_q("s2");
    chk("s2_drops", drop_s, exp_drops);
    chk("s2_sticky", irq_s, 1);
    clear_irq("s2c");

    // stall on first beat, then a clean packet
    start(2);
    gen($urandom_range(2, 5));
    push_src_exp(0);
    drive();
    wait_irq("s3", stalls);
    chk("s3_stalls", stalls, TMO);
    exp_drops++;
    rdy_mode = 0;
    drive();
    wait_idle("s3a");
    gen($urandom_range(1, 5));
    push_src_exp(1);
    drive();
    wait_idle("s3b");
    cmp_q("s3");
    chk("s3_drops", drop_s, exp_drops);
    clear_irq("s3c");

    // terminator itself times out
    start(3);
    rdy_lim = 1;
    gen(4);
    a0 = pkt[0];
    push_src_exp(0);
    gen(3);
    push_src_exp(0);
    exp_q.push_back(a0);
    exp_q.push_back(term_b);
    drive();
    exp_drops += 2;
    wait_drops("s4", exp_drops);
    rdy_mode = 0;
    drive();
    wait_idle("s4a");
    gen($urandom_range(2, 4));
    push_src_exp(1);
    drive();
    wait_idle("s4b");
    cmp_q("s4");
    chk("s4_drops", drop_s, exp_drops);
    clear_irq("s4c");

    // clear coinciding with timeout
    start(2);
    gen(1);
    push_src_exp(0);
    drive();
    stalls = 0;
    for (int n = 0; n < 50 && stalls < TMO; n++) begin
      tick();
      if (stall_s) stalls++;
    end
    timeout_error_clear = 1'b1;
    tick();
    chk("s5_tmo_irq", irq_s, 1);
    timeout_error_clear = 1'b0;
    tick();
    chk("s5_set_wins", irq_s, 1);
    exp_drops++;
    chk("s5_drops", drop_s, exp_drops);
    rdy_mode = 0;
    drive();
    wait_idle("s5");
    chk("s5_none", got.size(), 0);
    clear_irq("s5c");

    // reset while dropping an open packet
    start(3);
    rdy_lim = 1;
    gen(4);
    src.push_back(pkt[0]);
    src.push_back(pkt[1]);
    drive();
    wait_irq("s6", stalls);
    tick();
    tick();
    chk("s6_in_drop", ir_s, 1);
    aresetn = 1'b0;
    tick();
    chk("s6_rst_vld", ov_s, 0);
    chk("s6_rst_rdy", ir_s, 0);
    aresetn = 1'b1;
    tick();
    chk("s6_drops", drop_s, 0);
    chk("s6_irq", irq_s, 0);
    chk("s6_vld", ov_s, 0);
    start(0);
    gen(3);
    push_src_exp(1);
    drive();
    wait_idle("s6");
    cmp_q("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
